pool2x2_gen: RTL and testbench



---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_reducer.sv | 50 +++++
 rtl/pool2x2_gen.sv | 115 +++++++++++
 tb/tb_pool2x2_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared encodings and helpers for the 2x2 grid reduction engine
package pool_pkg;

    localparam logic [1:0] POOL_SUM = 2'd0;
    localparam logic [1:0] POOL_AVG = 2'd1;
    localparam logic [1:0] POOL_MAX = 2'd2;
    localparam logic [1:0] POOL_MIN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } pool_state_e;

    // Two guard bits hold the exact sum of four samples.
    function automatic int acc_width(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/pool_reducer.sv
// rtl/pool_reducer.sv - combinational combine/compare/round step for one quad sample
module pool_reducer
    import pool_pkg::*;
#(
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [1:0]    mode,
    input  logic          first,
    input  logic [DW+1:0] acc_in,
    input  logic [DW-1:0] sample,
    output logic [DW+1:0] acc_out,
    output logic [DW+1:0] result
);

    localparam int AW = acc_width(DW);

    logic          fill;
    logic          rfill;
    logic          gt;
    logic          lt;
    logic [AW-1:0] ext;
    logic [AW-1:0] sum;
    logic [AW-1:0] rnd;

    assign fill = SIGNED ? sample[DW-1] : 1'b0;
    assign ext  = {{2{fill}}, sample};
    assign sum  = acc_in + ext;
    assign gt   = SIGNED ? ($signed(ext) > $signed(acc_in)) : (ext > acc_in);
    assign lt   = SIGNED ? ($signed(ext) < $signed(acc_in)) : (ext < acc_in);

    always_comb begin
        acc_out = acc_in;
        if (first) begin
            acc_out = ext;
        end else begin
            case (mode)
                POOL_SUM, POOL_AVG: acc_out = sum;
                POOL_MAX:           acc_out = gt ? ext : acc_in;
                default:            acc_out = lt ? ext : acc_in;
            endcase
        end
    end

    // Shift in the sign bit by hand so halves always round toward +inf.
    assign rnd    = acc_out + AW'(2);
    assign rfill  = SIGNED ? rnd[AW-1] : 1'b0;
    assign result = (mode == POOL_AVG) ? {{2{rfill}}, rnd[AW-1:2]} : acc_out;

endmodule

// File: rtl/pool2x2_gen.sv
// rtl/pool2x2_gen.sv - 2x2 quad reduction engine: scan FSM, addressing and read-latency pipe
module pool2x2_gen
    import pool_pkg::*;
#(
    parameter int LOG_N  = 3,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     rd_en,
    output logic [2*LOG_N-1:0]       rd_addr,
    input  logic [DW-1:0]            rd_data,
    output logic                     wr_en,
    output logic [2*(LOG_N-1)-1:0]   wr_addr,
    output logic [DW+1:0]            wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int AW  = acc_width(DW);
    localparam int CW  = 2 * LOG_N;
    localparam int H   = LOG_N - 1;

    pool_state_e   state;
    logic [1:0]    mode_r;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          vld_d;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [AW-1:0] red_result;

    // Scan index is {oy, ox, dy, dx}; the RAM wants {row, col} = {oy, dy, ox, dx}.
    function automatic logic [CW-1:0] scan_addr(input logic [CW-1:0] k);
        return {k[CW-1:H+2], k[1], k[H+1:2], k[0]};
    endfunction

    pool_reducer #(
        .DW     (DW),
        .SIGNED (SIGNED)
    ) u_reducer (
        .mode    (mode_r),
        .first   (cnt_d[1:0] == 2'd0),
        .acc_in  (acc),
        .sample  (rd_data),
        .acc_out (acc_nxt),
        .result  (red_result)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            mode_r  <= POOL_SUM;
            cnt     <= '0;
            cnt_d   <= '0;
            vld_d   <= 1'b0;
            acc     <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            // rd_data arrives one cycle after the strobe; cnt_d tags it.
            vld_d <= rd_en;
            cnt_d <= cnt;
            wr_en <= 1'b0;
            done  <= 1'b0;

            if (vld_d) begin
                acc <= acc_nxt;
                if (cnt_d[1:0] == 2'd3) begin
                    wr_en   <= 1'b1;
                    wr_addr <= cnt_d[CW-1:2];
                    wr_data <= red_result;
                    done    <= &cnt_d;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_READ;
                        mode_r  <= mode;
                        cnt     <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                ST_READ: begin
                    if (&cnt) begin
                        rd_en <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        rd_addr <= scan_addr(cnt + CW'(1));
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool2x2_gen.sv
// tb/tb_pool2x2_gen.sv - table-driven bench for pool2x2_gen, unsigned and signed instances
module tb_pool2x2_gen;
    import pool_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic [1:0] mode;

    logic       rd_en_u, wr_en_u, busy_u, done_u;
    logic [5:0] rd_addr_u;
    logic [3:0] wr_addr_u;
    logic [9:0] wr_data_u;
    logic [7:0] rdata_u;

    logic       rd_en_s, wr_en_s, busy_s, done_s;
    logic [5:0] rd_addr_s;
    logic [3:0] wr_addr_s;
    logic [9:0] wr_data_s;
    logic [7:0] rdata_s;

    logic [7:0] ram_u [64];
    logic [7:0] ram_s [64];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [9:0] res_u [16];
    logic [9:0] res_s [16];
    int nw_u, nw_s, first_cyc, done_cyc, addr_err;

    always #5 CLK = ~CLK;

    pool2x2_gen #(.LOG_N(3), .DW(8), .SIGNED(1'b0)) dut_u (
        .CLK(CLK), .RST(RST), .start(start), .mode(mode),
        .rd_en(rd_en_u), .rd_addr(rd_addr_u), .rd_data(rdata_u),
        .wr_en(wr_en_u), .wr_addr(wr_addr_u), .wr_data(wr_data_u),
        .busy(busy_u), .done(done_u)
    );

    pool2x2_gen #(.LOG_N(3), .DW(8), .SIGNED(1'b1)) dut_s (
        .CLK(CLK), .RST(RST), .start(start), .mode(mode),
        .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rdata_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .busy(busy_s), .done(done_s)
    );

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (rd_en_u) rdata_u <= ram_u[rd_addr_u];
        if (rd_en_s) rdata_s <= ram_s[rd_addr_s];
    end

    always @(negedge CLK) begin
        if (wr_en_u) begin
            if (nw_u < 16) begin
                res_u[nw_u] = wr_data_u;
                if (wr_addr_u != 4'(nw_u)) addr_err++;
            end
            if (nw_u == 0) first_cyc = cyc;
            if (done_u) done_cyc = cyc;
            nw_u++;
        end
        if (wr_en_s) begin
            if (nw_s < 16) res_s[nw_s] = wr_data_s;
            nw_s++;
        end
    end

    typedef struct {
        int         pat;
        logic [1:0] mode;
        bit         sgn;
        int         q;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_ram(input int pat);
        for (int i = 0; i < 64; i++) ram_u[i] = (pat == 0) ? 8'(i) : 8'hFF;
    endtask

    task automatic clear_capture();
        nw_u = 0; nw_s = 0; first_cyc = -1; done_cyc = -1; addr_err = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_u && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("done_seen", 32'(done_u), 32'd1);
        #1;
    endtask

    task automatic run_pass(input logic [1:0] m, output int ts);
        @(negedge CLK);
        clear_capture();
        mode  = m;
        start = 1'b1;
        ts    = cyc;
        @(negedge CLK);
        start = 1'b0;
        mode  = ~m;
        wait_done();
    endtask

    task automatic pass_checks(input int ts, input string tag);
        chk({tag, "_writes_u"}, 32'(nw_u), 32'd16);
        chk({tag, "_writes_s"}, 32'(nw_s), 32'd16);
        chk({tag, "_first_wr_cycle"}, 32'(first_cyc), 32'(ts + 6));
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(ts + 66));
        chk({tag, "_wr_addr_order"}, 32'(addr_err), 32'd0);
    endtask

    initial begin
        int ts;
        int prev_key;
        int key;

        vecs[0]  = '{0, POOL_SUM, 1'b0, 0,  10'd18};
        vecs[1]  = '{0, POOL_SUM, 1'b0, 1,  10'd26};
        vecs[2]  = '{0, POOL_SUM, 1'b0, 15, 10'd234};
        vecs[3]  = '{0, POOL_SUM, 1'b1, 0,  10'h3FE};
        vecs[4]  = '{0, POOL_SUM, 1'b1, 1,  10'h38D};
        vecs[5]  = '{0, POOL_AVG, 1'b0, 0,  10'd5};
        vecs[6]  = '{0, POOL_AVG, 1'b0, 1,  10'd7};
        vecs[7]  = '{0, POOL_AVG, 1'b0, 15, 10'd59};
        vecs[8]  = '{0, POOL_AVG, 1'b1, 0,  10'd0};
        vecs[9]  = '{0, POOL_AVG, 1'b1, 1,  10'h3E3};
        vecs[10] = '{0, POOL_MAX, 1'b1, 0,  10'd127};
        vecs[11] = '{0, POOL_MAX, 1'b1, 1,  10'h3FD};
        vecs[12] = '{0, POOL_MAX, 1'b0, 5,  10'd27};
        vecs[13] = '{0, POOL_MIN, 1'b1, 0,  10'h380};
        vecs[14] = '{0, POOL_MIN, 1'b1, 1,  10'h39C};
        vecs[15] = '{0, POOL_MIN, 1'b0, 5,  10'd18};
        vecs[16] = '{1, POOL_SUM, 1'b0, 0,  10'd1020};
        vecs[17] = '{1, POOL_SUM, 1'b0, 9,  10'd1020};
        vecs[18] = '{1, POOL_AVG, 1'b0, 3,  10'd255};
        vecs[19] = '{1, POOL_MAX, 1'b0, 7,  10'd255};

        for (int i = 0; i < 64; i++) ram_s[i] = 8'h00;
        ram_s[0]  = 8'h80; ram_s[1]  = 8'h7F; ram_s[8]  = 8'h00; ram_s[9]  = 8'hFF;
        ram_s[2]  = 8'hFB; ram_s[3]  = 8'hFD; ram_s[10] = 8'hF9; ram_s[11] = 8'h9C;
        load_ram(0);
        clear_capture();

        RST = 1'b1; start = 1'b0; mode = POOL_SUM;
        repeat (3) @(negedge CLK);
        chk("reset_outputs_u", 32'({rd_en_u, wr_en_u, busy_u, done_u, rd_addr_u, wr_addr_u, wr_data_u}), 32'd0);
        chk("reset_outputs_s", 32'({rd_en_s, wr_en_s, busy_s, done_s, rd_addr_s, wr_addr_s, wr_data_s}), 32'd0);
        RST = 1'b0;

        prev_key = -1;
        for (int i = 0; i < 20; i++) begin
            key = vecs[i].pat * 4 + int'(vecs[i].mode);
            if (key != prev_key) begin
                load_ram(vecs[i].pat);
                run_pass(vecs[i].mode, ts);
                pass_checks(ts, $sformatf("pass%0d", key));
                prev_key = key;
            end
            chk($sformatf("vec%0d", i), 32'(vecs[i].sgn ? res_s[vecs[i].q] : res_u[vecs[i].q]), 32'(vecs[i].exp));
        end

        // start during the done cycle is dropped; one cycle later it is taken
        load_ram(0);
        run_pass(POOL_SUM, ts);
        start = 1'b1;
        mode  = POOL_SUM;
        @(negedge CLK);
        chk("start_in_done_ignored", 32'(busy_u), 32'd0);
        clear_capture();
        ts = cyc;
        @(negedge CLK);
        start = 1'b0;
        chk("start_after_done_accepted", 32'(busy_u), 32'd1);
        wait_done();
        chk("restart_done_cycle", 32'(done_cyc), 32'(ts + 66));
        chk("restart_q0", 32'(res_u[0]), 32'd18);

        // reset in the middle of a pass
        @(negedge CLK);
        clear_capture();
        mode = POOL_SUM; start = 1'b1; ts = cyc;
        @(negedge CLK);
        start = 1'b0;
        while (cyc < ts + 20) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_outputs_u", 32'({rd_en_u, wr_en_u, busy_u, done_u, rd_addr_u, wr_addr_u, wr_data_u}), 32'd0);
        chk("rst_mid_outputs_s", 32'({rd_en_s, wr_en_s, busy_s, done_s, rd_addr_s, wr_addr_s, wr_data_s}), 32'd0);
        RST = 1'b0;
        nw_u = 0;
        repeat (10) @(negedge CLK);
        chk("no_write_after_rst", 32'(nw_u), 32'd0);
        chk("idle_after_rst", 32'(busy_u), 32'd0);
        run_pass(POOL_SUM, ts);
        pass_checks(ts, "post_rst");
        chk("post_rst_q0", 32'(res_u[0]), 32'd18);
        chk("post_rst_q15", 32'(res_u[15]), 32'd234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
